spi_bus_arbiter: RTL
====================

Name: spi_bus_arbiter

Overview:
Shares one SPI byte engine and its SCLK/MOSI/MISO lines between N requesters, each owning a dedicated active-low slave select.
- Grants the bus round-robin.
- Sequences chip-select setup, byte-by-byte transfer handshakes, chip-select hold and inter-transaction gap.
- Sits between client blocks (sensor readers, flash loaders) and the shared SPI master engine.

Parameters:
N, 3, number of requesters (2..8)
SETUP_CYC, 2, clk_i cycles from ss_no assertion to first byte start (0 allowed)
HOLD_CYC, 2, clk_i cycles from last byte done to ss_no deassertion (0 allowed)
GAP_CYC, 1, clk_i cycles of idle bus after ss_no deassertion before next grant (0 allowed)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
req_i  input  N  per-requester transaction request, held high for the whole transaction
tx_valid_i  input  N  per-requester byte-to-send valid
tx_data_i  input  8*N  per-requester byte to send; requester k uses bits [8k+7:8k]
last_i  input  N  per-requester flag: current tx byte is last of the transaction
tx_ready_o  output  N  per-requester byte accepted strobe (valid&ready = handshake)
rx_valid_o  output  N  one-cycle pulse, received byte available for that requester
rx_data_o  output  8  received byte, shared, qualified by rx_valid_o
gnt_o  output  N  one-hot grant, held from grant to end of HOLD
ss_no  output  N  slave selects, active low, at most one low
eng_start_o  output  1  one-cycle pulse to start one byte transfer
eng_tx_o  output  8  byte for engine, stable from eng_start_o until eng_done_i
eng_done_i  input  1  one-cycle pulse from engine: byte complete
eng_rx_i  input  8  byte received by engine, valid with eng_done_i

Behaviour:
- Reset (async assert, sync release): state IDLE, gnt_o=0, ss_no all 1, tx_ready_o=0, rx_valid_o=0, rx_data_o=0, eng_start_o=0, eng_tx_o=0, rr pointer=0, counters=0. Mid-transfer reset releases ss_no immediately; the engine is reset separately.
- All outputs registered.
- States: IDLE, SETUP, WAIT_TX, XFER, HOLD, GAP.
- IDLE: if req_i!=0, pick the first set bit searching from pointer upward with wrap to 0. Next cycle: gnt_o[g]=1, ss_no[g]=0, counter=SETUP_CYC, go to SETUP. If req_i==0, stay in IDLE.
- SETUP: if counter==0 go to WAIT_TX; else decrement. SETUP_CYC=0 gives one SETUP cycle. Grant-to-first-tx_ready latency is SETUP_CYC+1 cycles.
- WAIT_TX: tx_ready_o[g]=1, all other bits 0.
  - On tx_valid_i[g]: latch tx_data_i slice into eng_tx_o, latch last_i[g], pulse eng_start_o next cycle, go to XFER. tx_ready_o drops the same cycle as the handshake.
  - If req_i[g] falls while waiting, abort: go to HOLD without starting a byte.
- XFER: wait for eng_done_i. Then rx_data_o=eng_rx_i and rx_valid_o[g]=1 for one cycle. Go to HOLD if the latched last flag is set, else WAIT_TX.
  - A req_i[g] drop during XFER is ignored; the byte completes, then the arbiter goes to HOLD.
  - eng_done_i outside XFER is ignored.
- HOLD: counter=HOLD_CYC on entry, count down to 0. Then ss_no[g]=1, gnt_o=0, pointer=(g+1) mod N, counter=GAP_CYC, go to GAP.
- GAP: count down to 0, then go to IDLE. Arbitration happens only in IDLE, so there are no grant changes mid-transaction.
- Requests arriving in any non-IDLE state wait.
- Simultaneous requests resolve by pointer order.
- A lone requester may be re-granted after GAP.
- tx_valid_i/req_i on non-granted requesters have no effect.
- Invariants: $onehot0(gnt_o); ss_no == ~gnt_o during SETUP..HOLD.

Test Plan:
- Single transaction. N=3, SETUP=2, HOLD=2, GAP=1. req_i=001; 2 bytes 0xA5, 0x3C (last on 0x3C); engine loops back tx^0xFF after 16 cycles.
  - ss_no=110 one cycle after req.
  - First tx_ready_o 3 cycles after grant.
  - rx_valid_o pulses carry 0x5A, then 0xC3.
  - ss_no returns to 111 three cycles after the second eng_done_i.
- Round-robin. req_i=111 held, one byte each.
  - Grant order: 0, 1, 2, 0.
  - Each ss_no high for at least GAP_CYC+1 cycles between grants.
- Contention after wrap. Pointer=2; req_i=011 set simultaneously.
  - Requester 0 granted first, then requester 1.
- Abort in WAIT_TX. req_i[1] dropped before any tx_valid_i.
  - No eng_start_o pulse.
  - ss_no[1] deasserts after HOLD_CYC.
  - Pointer advances to 2.
- Request drop in XFER. req_i dropped mid-byte.
  - Byte completes and rx_valid_o pulses once.
  - Arbiter goes to HOLD; no further tx_ready_o.
- Async reset mid-XFER. Assert rst_ni low between clock edges.
  - ss_no=all 1 and gnt_o=0 before the next clock edge.
  - After release, a new req_i=100 is granted to requester 2.

Source files
------------

// File: rtl/spi_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_bus_arbiter_if
// Bundle of every non-clock signal around spi_bus_arbiter.
//   Client side : req_i, tx_valid_i, tx_data_i (8 bits per requester),
//                 last_i, tx_ready_o, rx_valid_o, rx_data_o, gnt_o
//   SPI side    : ss_no (one active-low select per requester)
//   Engine side : eng_start_o, eng_tx_o, eng_done_i, eng_rx_i
// The master modport is the arbiter's view; slave is the environment's view.
// ---------------------------------------------------------------------------
interface spi_bus_arbiter_if #(
  parameter int N = 3
);
  logic [N-1:0]   req_i;
  logic [N-1:0]   tx_valid_i;
  logic [8*N-1:0] tx_data_i;
  logic [N-1:0]   last_i;
  logic [N-1:0]   tx_ready_o;
  logic [N-1:0]   rx_valid_o;
  logic [7:0]     rx_data_o;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   ss_no;
  logic           eng_start_o;
  logic [7:0]     eng_tx_o;
  logic           eng_done_i;
  logic [7:0]     eng_rx_i;

  modport master (
    input  req_i, tx_valid_i, tx_data_i, last_i, eng_done_i, eng_rx_i,
    output tx_ready_o, rx_valid_o, rx_data_o, gnt_o, ss_no, eng_start_o, eng_tx_o
  );

  modport slave (
    output req_i, tx_valid_i, tx_data_i, last_i, eng_done_i, eng_rx_i,
    input  tx_ready_o, rx_valid_o, rx_data_o, gnt_o, ss_no, eng_start_o, eng_tx_o
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// ---------------------------------------------------------------------------
// spi_bus_arbiter
// Round-robin arbiter sharing one SPI byte engine between N requesters.
// It sequences chip-select setup, per-byte valid/ready handshakes towards
// the engine, chip-select hold and an idle gap between transactions.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : spi_bus_arbiter_if.master (client, slave-select, engine signals)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module spi_bus_arbiter #(
  parameter int N         = 3,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  spi_bus_arbiter_if.master   bus
);

  localparam int IDX_W = $clog2(N);
  localparam int SUM_W = IDX_W + 1;
  localparam int MAX_AB = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_C  = (MAX_AB > GAP_CYC) ? MAX_AB : GAP_CYC;
  localparam int CNT_W  = (MAX_C < 1) ? 1 : $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WAIT_TX = 3'd2,
    ST_XFER    = 3'd3,
    ST_HOLD    = 3'd4,
    ST_GAP     = 3'd5
  } state_e;

  function automatic logic [N-1:0] onehot_f(input logic [IDX_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic             last_q, last_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [N-1:0]     ss_n_q, ss_n_d;
  logic [N-1:0]     tx_ready_q, tx_ready_d;
  logic [N-1:0]     rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             eng_start_q, eng_start_d;
  logic [7:0]       eng_tx_q, eng_tx_d;

  logic             pick_vld_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic [SUM_W-1:0] sum_s;
  logic [7:0]       tx_sel_s;
  logic             g_req_s;
  logic             g_valid_s;

  assign g_req_s   = bus.req_i[gidx_q];
  assign g_valid_s = bus.tx_valid_i[gidx_q];

  // Round-robin pick: first set request at or above the pointer, wrapping to 0.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_idx_s = '0;
    sum_s      = '0;
    for (int i = 0; i < N; i++) begin
      sum_s = {1'b0, ptr_q} + SUM_W'(i);
      if (sum_s >= SUM_W'(N)) begin
        sum_s = sum_s - SUM_W'(N);
      end else begin
        sum_s = sum_s;
      end
      if (!pick_vld_s && bus.req_i[sum_s[IDX_W-1:0]]) begin
        pick_vld_s = 1'b1;
        pick_idx_s = sum_s[IDX_W-1:0];
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Byte offered by the granted requester.
  always_comb begin
    tx_sel_s = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        tx_sel_s = bus.tx_data_i[8*i +: 8];
      end else begin
        tx_sel_s = tx_sel_s;
      end
    end
  end

  // State and output registers; reset releases every slave select at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      gidx_q      <= '0;
      last_q      <= 1'b0;
      gnt_q       <= '0;
      ss_n_q      <= '1;
      tx_ready_q  <= '0;
      rx_valid_q  <= '0;
      rx_data_q   <= 8'h00;
      eng_start_q <= 1'b0;
      eng_tx_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      ss_n_q      <= ss_n_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      eng_start_q <= eng_start_d;
      eng_tx_q    <= eng_tx_d;
    end
  end

  // Next state and phase counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_s) begin
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(SETUP_CYC);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT_TX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT_TX: begin
        // A dropped request wins over a simultaneous byte offer.
        if (!g_req_s) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC);
        end else if (g_valid_s) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_WAIT_TX;
        end
      end
      ST_XFER: begin
        // The byte in flight always completes; a dropped request ends the
        // transaction afterwards as if the byte had been the last one.
        if (bus.eng_done_i) begin
          if (last_q || !g_req_s) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_W'(HOLD_CYC);
          end else begin
            state_d = ST_WAIT_TX;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(GAP_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs, derived from the transition being taken.
  always_comb begin
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    ss_n_d      = ss_n_q;
    tx_ready_d  = '0;
    rx_valid_d  = '0;
    rx_data_d   = rx_data_q;
    eng_start_d = 1'b0;
    eng_tx_d    = eng_tx_q;

    if (state_d == ST_WAIT_TX) begin
      tx_ready_d = onehot_f(gidx_q);
    end else begin
      tx_ready_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_SETUP) begin
          gidx_d = pick_idx_s;
          gnt_d  = onehot_f(pick_idx_s);
          ss_n_d = ~onehot_f(pick_idx_s);
        end else begin
          gidx_d = gidx_q;
        end
      end
      ST_WAIT_TX: begin
        if (state_d == ST_XFER) begin
          eng_tx_d    = tx_sel_s;
          last_d      = bus.last_i[gidx_q];
          eng_start_d = 1'b1;
        end else begin
          eng_start_d = 1'b0;
        end
      end
      ST_XFER: begin
        if (bus.eng_done_i) begin
          rx_data_d  = bus.eng_rx_i;
          rx_valid_d = onehot_f(gidx_q);
        end else begin
          rx_valid_d = '0;
        end
      end
      ST_HOLD: begin
        if (state_d == ST_GAP) begin
          gnt_d  = '0;
          ss_n_d = '1;
          if (gidx_q == IDX_W'(N - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = gidx_q + IDX_W'(1);
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      default: begin
        gnt_d = gnt_q;
      end
    endcase
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.ss_no       = ss_n_q;
  assign bus.tx_ready_o  = tx_ready_q;
  assign bus.rx_valid_o  = rx_valid_q;
  assign bus.rx_data_o   = rx_data_q;
  assign bus.eng_start_o = eng_start_q;
  assign bus.eng_tx_o    = eng_tx_q;

endmodule
